// File: rtl/zwait_pkg.sv
// Shared constants for the Z80 wait scheduler: FSM encoding, default watchdog and source indices.
package zwait_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StHold    = ST_HOLD,
    StRelease = ST_RELEASE
  } zwait_state_e;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  localparam int unsigned SRC_GLUCLOCK = 0;
  localparam int unsigned SRC_COMPORT  = 1;

endpackage

// File: rtl/zwait_sched_if.sv
// Request/service bundle between the wait sources, the AVR side and the scheduler.
interface zwait_sched_if #(
  parameter int unsigned NREQ = 7,
  parameter int unsigned IDW  = 3
);

  logic [NREQ-1:0] req_stb;
  logic            end_stb;
  logic            timeout_clr;
  logic [NREQ-1:0] waits;
  logic [IDW-1:0]  cur_id;
  logic            cur_vld;
  logic            wait_req;
  logic            spiint_n;
  logic            timeout_flag;

  modport master (
    output req_stb, end_stb, timeout_clr,
    input  waits, cur_id, cur_vld, wait_req, spiint_n, timeout_flag
  );

  modport slave (
    input  req_stb, end_stb, timeout_clr,
    output waits, cur_id, cur_vld, wait_req, spiint_n, timeout_flag
  );

endinterface

// File: rtl/zwait_prienc.sv
// Lowest-set-bit priority encoder; index 0 has the highest priority.
module zwait_prienc #(
  parameter int unsigned NREQ = 7,
  parameter int unsigned IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) idx = IDW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/zwait_sched.sv
// Z80 wait scheduler: queues wait requests, serves one at a time to the AVR, with watchdog release.
module zwait_sched
  import zwait_pkg::*;
#(
  parameter int unsigned    NREQ    = 7,
  parameter int unsigned    IDW     = 3,
  parameter int unsigned    CW      = 16,
  parameter logic [CW-1:0]  TIMEOUT = CW'(TIMEOUT_DEFAULT)
) (
  input logic          fclk,
  input logic          rst,
  zwait_sched_if.slave bus
);

  zwait_state_e    state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tflag_q, tflag_d;

  logic [IDW-1:0]  pri_idx;
  logic            pri_any;
  logic            leave_hold;
  logic            tmo_set;
  logic [NREQ-1:0] clr_mask;

  zwait_prienc #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_prienc (
    .req (pending_q),
    .idx (pri_idx),
    .any (pri_any)
  );

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    cnt_d      = cnt_q;
    leave_hold = 1'b0;
    tmo_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pri_any) begin
          cur_id_d = pri_idx;
          cnt_d    = '0;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        // A normal end beats a coincident watchdog expiry.
        if (bus.end_stb) begin
          leave_hold = 1'b1;
          state_d    = StRelease;
        end else if ((TIMEOUT != '0) && (cnt_q == TIMEOUT - CW'(1))) begin
          leave_hold = 1'b1;
          tmo_set    = 1'b1;
          state_d    = StRelease;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    clr_mask  = leave_hold ? (NREQ'(1) << cur_id_q) : '0;
    // New strobes are OR-ed in last so a same-edge request re-queues the source.
    pending_d = (pending_q & ~clr_mask) | bus.req_stb;
    tflag_d   = tmo_set | (tflag_q & ~bus.timeout_clr);
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      cur_id_q  <= '0;
      cnt_q     <= '0;
      tflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_id_q  <= cur_id_d;
      cnt_q     <= cnt_d;
      tflag_q   <= tflag_d;
    end
  end

  assign bus.waits        = pending_q;
  assign bus.wait_req     = |pending_q;
  assign bus.cur_id       = cur_id_q;
  assign bus.cur_vld      = (state_q == StHold);
  assign bus.spiint_n     = ~bus.cur_vld;
  assign bus.timeout_flag = tflag_q;

endmodule

// File: tb/tb_zwait_sched.sv
// Self-checking bench for zwait_sched: directed scenarios plus random strobes against a service model.
module tb_zwait_sched;

  localparam int unsigned NREQ = 7;
  localparam int unsigned IDW  = 3;
  localparam int          TMO  = 16;

  logic fclk;
  logic rst;

  int checks = 0;
  int errors = 0;

  zwait_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  zwait_sched #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .CW      (16),
    .TIMEOUT (16'(TMO))
  ) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // Service model: pending set, the source being served and how long it has been held.
  bit [NREQ-1:0] m_pend;
  int            m_act;
  int            m_held;
  int            m_gap;
  bit            m_tflag;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [NREQ-1:0] p);
    for (int i = 0; i < int'(NREQ); i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_act   = -1;
    m_held  = 0;
    m_gap   = 0;
    m_tflag = 0;
  endtask

  task automatic model_edge(input bit [NREQ-1:0] r, input bit e, input bit c);
    bit [NREQ-1:0] clr = '0;
    bit            tset = 0;
    if (m_act >= 0) begin
      if (e || (m_held + 1 == TMO)) begin
        clr[m_act] = 1'b1;
        tset       = !e;
        m_act      = -1;
        m_gap      = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_pend != '0) begin
      m_act  = lowest(m_pend);
      m_held = 0;
    end
    m_pend  = (m_pend & ~clr) | r;
    m_tflag = tset ? 1'b1 : (c ? 1'b0 : m_tflag);
  endtask

  task automatic compare_all();
    check_eq("waits", 32'(bus.waits), 32'(m_pend));
    check_eq("wait_req", 32'(bus.wait_req), 32'(m_pend != '0));
    check_eq("cur_vld", 32'(bus.cur_vld), 32'(m_act >= 0));
    check_eq("spiint_n", 32'(bus.spiint_n), 32'(m_act < 0));
    check_eq("timeout_flag", 32'(bus.timeout_flag), 32'(m_tflag));
    if (m_act >= 0) check_eq("cur_id", 32'(bus.cur_id), 32'(m_act));
  endtask

  task automatic step(input bit [NREQ-1:0] r, input bit e, input bit c);
    @(negedge fclk);
    bus.req_stb     = r;
    bus.end_stb     = e;
    bus.timeout_clr = c;
    @(posedge fclk);
    model_edge(r, e, c);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_stb     = '0;
    bus.end_stb     = 1'b0;
    bus.timeout_clr = 1'b0;
    model_reset();
    @(posedge fclk);
    #1;
    compare_all();
    check_eq("rst_cur_id", 32'(bus.cur_id), 32'd0);
    @(negedge fclk);
    rst = 1'b0;

    // Single request from the comport source.
    step(7'b0000010, 1'b0, 1'b0);
    check_eq("single_wait_req", 32'(bus.wait_req), 32'd1);
    step('0, 1'b0, 1'b0);
    check_eq("single_cur_id", 32'(bus.cur_id), 32'd1);
    check_eq("single_spiint_n", 32'(bus.spiint_n), 32'd0);
    idle(8);
    step('0, 1'b1, 1'b0);
    check_eq("single_end_waits", 32'(bus.waits), 32'd0);
    check_eq("single_end_vld", 32'(bus.cur_vld), 32'd0);
    idle(3);

    // Source 1 in service, source 0 arrives later and must not preempt.
    step(7'b0000010, 1'b0, 1'b0);
    idle(2);
    step(7'b0000001, 1'b0, 1'b0);
    check_eq("prio_no_preempt", 32'(bus.cur_id), 32'd1);
    idle(4);
    step('0, 1'b1, 1'b0);
    check_eq("prio_gap0", 32'(bus.spiint_n), 32'd1);
    idle(1);
    check_eq("prio_gap1", 32'(bus.spiint_n), 32'd1);
    idle(1);
    check_eq("prio_grant0", 32'(bus.cur_id), 32'd0);
    check_eq("prio_wait_held", 32'(bus.wait_req), 32'd1);
    step('0, 1'b1, 1'b0);
    idle(3);

    // Watchdog release, then clear.
    step(7'b0000100, 1'b0, 1'b0);
    idle(TMO);
    check_eq("tmo_not_yet", 32'(bus.timeout_flag), 32'd0);
    idle(1);
    check_eq("tmo_flag", 32'(bus.timeout_flag), 32'd1);
    check_eq("tmo_waits", 32'(bus.waits), 32'd0);
    step('0, 1'b0, 1'b1);
    check_eq("tmo_clr", 32'(bus.timeout_flag), 32'd0);
    idle(2);

    // Clear on the same edge as a new expiry: set wins.
    step(7'b0001000, 1'b0, 1'b0);
    idle(TMO);
    step('0, 1'b0, 1'b1);
    check_eq("tmo_set_wins", 32'(bus.timeout_flag), 32'd1);
    step('0, 1'b0, 1'b1);
    idle(2);

    // End on the expiry edge is a normal end.
    step(7'b0010000, 1'b0, 1'b0);
    idle(TMO);
    step('0, 1'b1, 1'b0);
    check_eq("end_on_tmo", 32'(bus.timeout_flag), 32'd0);
    idle(2);

    // Re-request on the end edge of the active source.
    step(7'b0000100, 1'b0, 1'b0);
    idle(4);
    step(7'b0000100, 1'b1, 1'b0);
    check_eq("requeue_waits", 32'(bus.waits), 32'h4);
    idle(2);
    check_eq("requeue_regrant", 32'(bus.cur_id), 32'd2);
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    idle(1);

    // Stray end in idle; repeated request merges into one service.
    step('0, 1'b1, 1'b0);
    step(7'b0000001, 1'b0, 1'b0);
    step(7'b0000001, 1'b0, 1'b0);
    step(7'b0000001, 1'b0, 1'b0);
    idle(2);
    step('0, 1'b1, 1'b0);
    idle(4);
    check_eq("merge_single", 32'(bus.cur_vld), 32'd0);

    // Asynchronous reset in the middle of HOLD with two sources pending.
    step(7'b0000011, 1'b0, 1'b0);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst_waits", 32'(bus.waits), 32'd0);
    check_eq("arst_wait_req", 32'(bus.wait_req), 32'd0);
    check_eq("arst_spiint_n", 32'(bus.spiint_n), 32'd1);
    check_eq("arst_cur_vld", 32'(bus.cur_vld), 32'd0);
    @(negedge fclk);
    rst = 1'b0;
    idle(2);

    // Random strobes.
    for (int n = 0; n < 2000; n++) begin
      bit [NREQ-1:0] r;
      r = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
      step(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zwait_sched.md
Name: zwait_sched

Overview:
- Synchronous Z80 wait scheduler for the fclk domain. Collects wait requests from up to NREQ sources (gluclock, comport, spares) and stretches Z80 WAIT while any request is outstanding.
- Presents exactly one active request at a time to the AVR through the SPI interrupt and a source ID.
- Releases the active request on the AVR end strobe or on a timeout watchdog, then serves the next pending one.
- The top level converts wait_req into the open-drain /WAIT pin.

Parameters:
- NREQ, 7: number of request sources, 1..8.
- IDW, 3: width of cur_id; must satisfy 2^IDW >= NREQ.
- CW, 16: width of the timeout counter.
- TIMEOUT, 16'd50000: fclk cycles in HOLD before forced release; 0 disables the watchdog.

Ports:
- fclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_stb  in  NREQ  one-cycle request strobes, already synchronized to fclk; bit i = source i.
- end_stb  in  1  one-cycle AVR "wait done" strobe for the active request.
- timeout_clr  in  1  one-cycle clear of timeout_flag.
- waits  out  NREQ  pending bitmap; includes the active request.
- cur_id  out  IDW  index of the active request; valid while cur_vld=1.
- cur_vld  out  1  an active request is being served.
- wait_req  out  1  1 = hold Z80 WAIT asserted.
- spiint_n  out  1  active-low AVR interrupt.
- timeout_flag  out  1  sticky: a forced release has occurred.

Behaviour:
Reset
- While rst=1, immediately: pending=0, state=IDLE, cnt=0, cur_id=0, cur_vld=0, timeout_flag=0.
- Outputs during reset: wait_req=0, spiint_n=1.
- Reset asserted mid-HOLD aborts service at once. No end or timeout event is generated.

Pending register
- pending[i] is set at the edge where req_stb[i]=1.
- It is cleared at the edge where source i leaves HOLD.
- Set and clear on the same edge: set wins. The request is re-queued and served again later.
- A repeat request while already pending merges into the existing bit, with no double service.
- waits = pending, registered.

Combinational outputs
- wait_req = |pending, taken straight from the flops with no glitch path.
- spiint_n = ~cur_vld.

State machine (IDLE, HOLD, RELEASE)
- IDLE: if pending != 0, latch cur_id = lowest set index (fixed priority, 0 highest), clear cnt, go to HOLD. Otherwise stay in IDLE.
- HOLD: cur_vld=1 and cnt increments, saturating at all-ones.
  - end_stb=1: go to RELEASE. This is a normal end. If the timeout condition is also true on the same edge, timeout_flag is not set.
  - Otherwise, if TIMEOUT != 0 and cnt == TIMEOUT-1: go to RELEASE and set timeout_flag.
  - In both cases pending[cur_id] is cleared on that same edge.
- RELEASE: cur_vld=0 for one cycle, then go to IDLE. This guarantees an spiint_n deassert gap.
- end_stb outside HOLD is ignored.
- Requests arriving during HOLD are only latched; there is no preemption, even by a higher-priority source.

Latency
- req_stb at edge 0 → wait_req=1 after edge 0.
- From IDLE: cur_vld=1 and spiint_n=0 after edge 1.
- end_stb at edge k → cur_vld=0 after edge k.
- The next grant appears after edge k+2 at the earliest (RELEASE, then IDLE).
- With another request still pending, wait_req stays 1 continuously across the handover.

timeout_flag
- Set by a forced release; cleared by timeout_clr.
- Set and clear on the same edge: set wins.

Widths
- cnt compare is done at CW bits. TIMEOUT must be below 2^CW.

Decomposition:
- Shared package zwait_pkg: state encoding constants (ST_IDLE=2'd0, ST_HOLD=2'd1, ST_RELEASE=2'd2), the default TIMEOUT, and source index constants (SRC_GLUCLOCK=0, SRC_COMPORT=1).
- One sub-module, zwait_prienc: a combinational lowest-set-bit priority encoder, NREQ → IDW plus an any-bit output.
- Everything else lives in zwait_sched.

Test Plan:
- Reset: assert rst mid-HOLD with pending=7'b0000011 → waits=0, wait_req=0, spiint_n=1, cur_vld=0, all asynchronously, before the next fclk edge.
- Single request: req_stb=7'b0000010 at edge 0 → wait_req=1 after edge 0, cur_id=1 and spiint_n=0 after edge 1. end_stb at edge 10 → waits=0, wait_req=0 and cur_vld=0 after edge 10.
- Priority and no preemption: req_stb[1] at edge 0; req_stb[0] at edge 3, while source 1 is already in HOLD. end_stb at edge 8 → cur_id=0 granted after edge 10, wait_req=1 throughout, spiint_n high for exactly edges 8..10.
- Timeout: TIMEOUT=16, request with no end_stb → release after 16 HOLD cycles, timeout_flag=1 and waits=0. timeout_clr → flag 0. timeout_clr together with a new timeout on the same edge → flag stays 1.
- Simultaneous events: req_stb[2] on the same edge as end_stb for active id 2 → waits[2] stays 1 and source 2 is re-served after the RELEASE/IDLE gap. end_stb on the timeout edge → timeout_flag stays 0.
- Stray strobes: end_stb in IDLE and in RELEASE → no state change. A repeat req_stb[0] while pending[0]=1 → exactly one service.
